pipe_hazard_ctrl: RTL and testbench

//  Parametrised pipeline sequencer: owns all stage enables/flushes for the IF/ID/EX/MEM/WB core.

---
 rtl/hz_pkg.sv | 24 ++
 rtl/hz_sb_pipe.sv | 69 ++++++
 rtl/pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hz_pkg.sv
// Shared types for the pipeline hazard controller.
//   halt_state_t : halt drain FSM states (RUN, DRAIN, HALTED)
//   sb_entry_t   : one scoreboard slot, {valid, destination register}
//   MAX_READY_LAT: largest supported scoreboard depth
//   MAX_RW       : width of the stored register index (covers NREG up to 256)
package hz_pkg;

    localparam int MAX_READY_LAT = 8;
    localparam int MAX_RW        = 8;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    // The index field is sized for the largest register file.
    // Unused upper bits are always stored as zero.
    typedef struct packed {
        logic              v;
        logic [MAX_RW-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hz_sb_pipe.sv
// In-flight register write scoreboard: a READY_LAT-deep shift register of
// {valid, rd}. A register is pending while any slot holds a valid write to it.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears all slots)
//   advance     : shift one slot this cycle (no reset, no memory stall)
//   clear       : drop every in-flight write (taken branch)
//   wr_v, wr_rd : write entering slot 0 on an advancing cycle
//   pending     : bit r set while a write to r is in flight
//   empty_next  : no valid entry remains once the oldest slot drops off
module hz_sb_pipe
    import hz_pkg::*;
#(
    parameter int NREG      = 8,
    parameter int READY_LAT = 3,
    parameter int ZERO_REG  = 0,
    parameter int RW        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    input  logic            clear,
    input  logic            wr_v,
    input  logic [RW-1:0]   wr_rd,
    output logic [NREG-1:0] pending,
    output logic            empty_next
);

    sb_entry_t slots [READY_LAT];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int k = 0; k < READY_LAT; k++) begin
                slots[k] <= '0;
            end
        end else if (advance) begin
            slots[0] <= '{v: wr_v, rd: MAX_RW'(wr_rd)};
            for (int k = 1; k < READY_LAT; k++) begin
                slots[k] <= slots[k-1];
            end
        end
    end

    // Only prior slots are decoded, so an instruction in ID never hazards
    // against its own destination.
    always_comb begin
        pending = '0;
        for (int k = 0; k < READY_LAT; k++) begin
            for (int r = 0; r < NREG; r++) begin
                if (slots[k].v && (slots[k].rd == MAX_RW'(r))) begin
                    pending[r] = 1'b1;
                end
            end
        end
        if (ZERO_REG != 0) begin
            pending[0] = 1'b0;
        end
    end

    // The last slot drops on the next advance, so only younger slots matter.
    always_comb begin
        empty_next = 1'b1;
        for (int k = 0; k < READY_LAT - 1; k++) begin
            if (slots[k].v) begin
                empty_next = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the IF/ID/EX/MEM/WB core. It drives every stage
// enable and flush, stalls ID on RAW hazards against in-flight writes and on
// memory wait, flushes on a taken branch, and drains the pipe after HLT.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   id_valid/id_use_*/id_rs_*        : ID instruction and its source reads
//   id_regwrite/id_rd                : ID instruction destination write
//   id_halt                          : ID instruction is HLT
//   br_taken, mem_stall              : taken branch, memory not ready
//   en_*, flush_*                    : stage register enables / clears
//   issue                            : ID advances into EX this cycle
//   reg_pending                      : scoreboard view, one bit per register
//   halted                           : core halted until reset
//   dbg_state                        : halt FSM state
// Valid/ready: issue is the only handshake; ID advances exactly in cycles where
// issue=1, and an instruction held in ID keeps id_valid and its fields stable.
module pipe_hazard_ctrl
    import hz_pkg::*;
#(
    parameter int NREG      = 8,
    parameter int RW        = $clog2(NREG),
    parameter int READY_LAT = 3,
    parameter int ZERO_REG  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic            id_use_a,
    input  logic [RW-1:0]   id_rs_a,
    input  logic            id_use_b,
    input  logic [RW-1:0]   id_rs_b,
    input  logic            id_regwrite,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_halt,
    input  logic            br_taken,
    input  logic            mem_stall,
    output logic            en_pc,
    output logic            en_ifid,
    output logic            en_idex,
    output logic            en_exmem,
    output logic            en_memwb,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            flush_exmem,
    output logic            flush_memwb,
    output logic            issue,
    output logic [NREG-1:0] reg_pending,
    output logic            halted,
    output halt_state_t     dbg_state
);

    localparam int            CW       = $clog2(MAX_READY_LAT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(READY_LAT - 1);

    halt_state_t   state, state_next;
    logic [CW-1:0] drain_cnt, cnt_next;
    logic          advance;
    logic          hazard;
    logic          sb_empty_next;

    // The scoreboard and FSM move only when the whole pipe moves.
    assign advance = !reset && !mem_stall;

    hz_sb_pipe #(
        .NREG      (NREG),
        .READY_LAT (READY_LAT),
        .ZERO_REG  (ZERO_REG),
        .RW        (RW)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .advance    (advance),
        .clear      (br_taken && !mem_stall),
        .wr_v       (issue && id_regwrite),
        .wr_rd      (id_rd),
        .pending    (reg_pending),
        .empty_next (sb_empty_next)
    );

    assign hazard = id_valid && ((id_use_a && reg_pending[id_rs_a]) ||
                                 (id_use_b && reg_pending[id_rs_b]));

    always_comb begin
        en_pc       = 1'b1;
        en_ifid     = 1'b1;
        en_idex     = 1'b1;
        en_exmem    = 1'b1;
        en_memwb    = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        flush_memwb = 1'b0;
        issue       = 1'b0;
        if (reset) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            flush_memwb = 1'b1;
        end else if (mem_stall) begin
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
        end else if (br_taken) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            flush_memwb = 1'b1;
        end else if (state == HALTED) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
        end else if (state == DRAIN) begin
            // HLT is already downstream; anything fetched behind it is squashed.
            en_pc      = 1'b0;
            flush_ifid = 1'b1;
        end else if (hazard) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
        end else begin
            issue = id_valid;
        end
    end

    // drain_cnt counts advancing cycles spent in DRAIN; HALTED is entered at the
    // end of the READY_LAT-th one, once nothing is left in flight.
    always_comb begin
        state_next = state;
        cnt_next   = drain_cnt;
        if (advance) begin
            case (state)
                RUN: begin
                    if (!br_taken && issue && id_halt) begin
                        state_next = DRAIN;
                        cnt_next   = '0;
                    end
                end
                DRAIN: begin
                    if (br_taken) begin
                        state_next = RUN;
                    end else if ((drain_cnt == CNT_LAST) && sb_empty_next) begin
                        state_next = HALTED;
                    end else if (drain_cnt != CNT_LAST) begin
                        cnt_next = drain_cnt + CW'(1);
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= cnt_next;
        end
    end

    assign halted    = (state == HALTED);
    assign dbg_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  import hz_pkg::*;

  localparam int L = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_valid, id_use_a, id_use_b, id_regwrite, id_halt, br_taken, mem_stall;
  logic [2:0] id_rs_a, id_rs_b, id_rd;
  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic issue, halted;
  logic [7:0] reg_pending;
  halt_state_t dbg_state;

  pipe_hazard_ctrl #(.NREG(8), .READY_LAT(L), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_use_a(id_use_a), .id_rs_a(id_rs_a),
    .id_use_b(id_use_b), .id_rs_b(id_rs_b),
    .id_regwrite(id_regwrite), .id_rd(id_rd), .id_halt(id_halt),
    .br_taken(br_taken), .mem_stall(mem_stall),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .issue(issue), .reg_pending(reg_pending), .halted(halted), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic valid; logic use_a; logic [2:0] rs_a; logic use_b; logic [2:0] rs_b;
    logic regwrite; logic [2:0] rd; logic halt; logic br; logic ms; logic rst;
  } in_t;

  typedef struct {
    in_t i; logic [4:0] en; logic [3:0] fl; logic iss; logic [7:0] pend;
  } row_t;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [18:0] s_out;  // {en x5, flush x4, issue, reg_pending, halted}

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  // In-flight writes as a list of {register, advancing cycles still pending}.
  typedef struct { int rd; int left; } ent_t;
  ent_t m_q[$];
  int m_mode = 0;   // 0 running, 1 draining after HLT, 2 halted
  int m_since = 0;  // advancing cycles since HLT issued

  function automatic logic [7:0] m_pend();
    logic [7:0] p = '0;
    foreach (m_q[k]) p[m_q[k].rd] = 1'b1;
    return p;
  endfunction

  function automatic logic [18:0] m_out(input in_t v);
    logic [7:0] p = m_pend();
    logic [4:0] en = 5'b11111;
    logic [3:0] fl = 4'b0000;
    logic iss = 1'b0;
    logic haz = v.valid && ((v.use_a && p[v.rs_a]) || (v.use_b && p[v.rs_b]));
    if (v.rst) fl = 4'b1111;
    else if (v.ms) en = 5'b00000;
    else if (v.br) fl = 4'b1111;
    else if (m_mode == 2) begin en = 5'b00111; fl = 4'b0100; end
    else if (m_mode == 1) begin en = 5'b01111; fl = 4'b1000; end
    else if (haz) begin en = 5'b00111; fl = 4'b0100; end
    else iss = v.valid;
    return {en, fl, iss, p, (m_mode == 2)};
  endfunction

  task automatic m_update(input in_t v, input logic iss);
    ent_t nq[$];
    if (v.rst) begin
      m_q.delete(); m_mode = 0; m_since = 0;
    end else if (!v.ms) begin
      if (v.br) begin
        m_q.delete();
        if (m_mode == 1) m_mode = 0;
      end else begin
        foreach (m_q[k]) if (m_q[k].left > 1) nq.push_back('{m_q[k].rd, m_q[k].left - 1});
        m_q = nq;
        if (iss && v.regwrite) m_q.push_back('{int'(v.rd), L});
        if (m_mode == 0 && iss && v.halt) begin
          m_mode = 1; m_since = 0;
        end else if (m_mode == 1) begin
          m_since++;
          if (m_since >= L && m_q.size() == 0) m_mode = 2;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input in_t v, input string nm);
    logic [18:0] e;
    @(negedge clk);
    id_valid = v.valid; id_use_a = v.use_a; id_rs_a = v.rs_a;
    id_use_b = v.use_b; id_rs_b = v.rs_b; id_regwrite = v.regwrite;
    id_rd = v.rd; id_halt = v.halt; br_taken = v.br; mem_stall = v.ms; reset = v.rst;
    #1;
    e = m_out(v);
    s_out = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
             flush_ifid, flush_idex, flush_exmem, flush_memwb, issue, reg_pending, halted};
    chk(nm, 32'(s_out), 32'(e));
    @(posedge clk);
    m_update(v, e[9]);
  endtask

  function automatic in_t mk(logic valid, logic ua, int ra, logic ub, int rb,
                             logic rw, int rd, logic hlt, logic br, logic ms);
    in_t t;
    t.valid = valid; t.use_a = ua; t.rs_a = 3'(ra); t.use_b = ub; t.rs_b = 3'(rb);
    t.regwrite = rw; t.rd = 3'(rd); t.halt = hlt; t.br = br; t.ms = ms; t.rst = 1'b0;
    return t;
  endfunction

  row_t tbl[$];
  in_t idle, rst_in, hlt_in;

  initial begin
    reset = 1'b1; id_valid = 0; id_use_a = 0; id_rs_a = 0; id_use_b = 0; id_rs_b = 0;
    id_regwrite = 0; id_rd = 0; id_halt = 0; br_taken = 0; mem_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_flush", 32'({flush_ifid, flush_idex, flush_exmem, flush_memwb}), 32'hf);
    chk("rst_issue", 32'(issue), 32'h0);
    chk("rst_pend", 32'(reg_pending), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    @(posedge clk);

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_in = idle; rst_in.rst = 1'b1;
    hlt_in = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // RAW stall: 3 stall cycles, issue on the 4th
    tbl.push_back('{mk(1,0,0,0,0,1,3,0,0,0), 5'b11111, 4'b0000, 1'b1, 8'h00});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{mk(1,1,3,0,0,0,0,0,0,0), 5'b00111, 4'b0100, 1'b0, 8'h08});
    tbl.push_back('{mk(1,1,3,0,0,0,0,0,0,0), 5'b11111, 4'b0000, 1'b1, 8'h00});
    // independent write r3 then read/write r4
    tbl.push_back('{mk(1,0,0,0,0,1,3,0,0,0), 5'b11111, 4'b0000, 1'b1, 8'h00});
    tbl.push_back('{mk(1,1,4,0,0,1,4,0,0,0), 5'b11111, 4'b0000, 1'b1, 8'h08});
    tbl.push_back('{idle, 5'b11111, 4'b0000, 1'b0, 8'h18});
    tbl.push_back('{idle, 5'b11111, 4'b0000, 1'b0, 8'h18});
    tbl.push_back('{idle, 5'b11111, 4'b0000, 1'b0, 8'h10});
    tbl.push_back('{idle, 5'b11111, 4'b0000, 1'b0, 8'h00});
    // mem_stall for 2 cycles in the middle of a RAW stall: 5 stall cycles total
    tbl.push_back('{mk(1,0,0,0,0,1,3,0,0,0), 5'b11111, 4'b0000, 1'b1, 8'h00});
    tbl.push_back('{mk(1,1,3,0,0,0,0,0,0,0), 5'b00111, 4'b0100, 1'b0, 8'h08});
    tbl.push_back('{mk(1,1,3,0,0,0,0,0,0,1), 5'b00000, 4'b0000, 1'b0, 8'h08});
    tbl.push_back('{mk(1,1,3,0,0,0,0,0,0,1), 5'b00000, 4'b0000, 1'b0, 8'h08});
    tbl.push_back('{mk(1,1,3,0,0,0,0,0,0,0), 5'b00111, 4'b0100, 1'b0, 8'h08});
    tbl.push_back('{mk(1,1,3,0,0,0,0,0,0,0), 5'b00111, 4'b0100, 1'b0, 8'h08});
    tbl.push_back('{mk(1,1,3,0,0,0,0,0,0,0), 5'b11111, 4'b0000, 1'b1, 8'h00});
    // taken branch with r2, r5 pending
    tbl.push_back('{mk(1,0,0,0,0,1,2,0,0,0), 5'b11111, 4'b0000, 1'b1, 8'h00});
    tbl.push_back('{mk(1,0,0,0,0,1,5,0,0,0), 5'b11111, 4'b0000, 1'b1, 8'h04});
    tbl.push_back('{mk(1,1,2,0,0,0,0,0,1,0), 5'b11111, 4'b1111, 1'b0, 8'h24});
    tbl.push_back('{mk(1,1,2,0,0,0,0,0,0,0), 5'b11111, 4'b0000, 1'b1, 8'h00});

    foreach (tbl[k]) begin
      step(tbl[k].i, $sformatf("model_tbl%0d", k));
      chk($sformatf("tbl%0d", k), 32'(s_out),
          32'({tbl[k].en, tbl[k].fl, tbl[k].iss, tbl[k].pend, 1'b0}));
    end

    // HLT: 3 drain cycles, then halted and stays halted
    step(hlt_in, "hlt_issue");
    chk("hlt_issue", 32'(s_out[9]), 32'h1);
    for (int k = 0; k < L; k++) begin
      step(idle, "drain");
      chk($sformatf("drain%0d_en_pc", k), 32'(s_out[18]), 32'h0);
      chk($sformatf("drain%0d_flush_ifid", k), 32'(s_out[13]), 32'h1);
      chk($sformatf("drain%0d_halted", k), 32'(s_out[0]), 32'h0);
    end
    step(idle, "halted");
    chk("halted", 32'(s_out[0]), 32'h1);
    chk("halted_en_pc", 32'(s_out[18]), 32'h0);
    chk("halted_flush_idex", 32'(s_out[12]), 32'h1);
    step(mk(1,0,0,0,0,0,0,0,0,0), "halted_hold");
    chk("halted_hold", 32'({s_out[9], s_out[0]}), 32'h1);

    // reset out of HALTED, then br_taken during DRAIN returns to RUN
    step(rst_in, "rst_from_halt");
    chk("rst_flush_all", 32'(s_out[13:10]), 32'hf);
    step(hlt_in, "hlt2_issue");
    step(idle, "hlt2_drain");
    chk("hlt2_drain_en_pc", 32'(s_out[18]), 32'h0);
    step(mk(0,0,0,0,0,0,0,0,1,0), "drain_br");
    chk("drain_br_flush", 32'(s_out[13:10]), 32'hf);
    for (int k = 0; k < 4; k++) begin
      step(idle, "post_br");
      chk($sformatf("post_br%0d_run", k), 32'({s_out[18], s_out[0]}), 32'h2);
    end

    // reset mid-DRAIN with writes still pending
    step(mk(1,0,0,0,0,1,2,0,0,0), "md_wr2");
    step(mk(1,0,0,0,0,1,5,0,0,0), "md_wr5");
    step(hlt_in, "md_hlt");
    step(idle, "md_drain");
    chk("md_drain_pend", 32'(s_out[8:1]), 32'h24);
    chk("md_drain_en_pc", 32'(s_out[18]), 32'h0);
    step(rst_in, "md_rst");
    step(idle, "md_after");
    chk("md_after_pend", 32'(s_out[8:1]), 32'h0);
    chk("md_after_halted", 32'(s_out[0]), 32'h0);
    chk("md_after_en_pc", 32'(s_out[18]), 32'h1);

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      in_t v;
      v.valid = ($urandom_range(0, 3) != 0);
      v.use_a = $urandom_range(0, 1);
      v.rs_a = 3'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 7));
      v.use_b = $urandom_range(0, 1);
      v.rs_b = 3'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 7));
      v.regwrite = $urandom_range(0, 1);
      v.rd = 3'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 7));
      v.halt = ($urandom_range(0, 99) < 4);
      v.br = ($urandom_range(0, 99) < 8);
      v.ms = ($urandom_range(0, 99) < 20);
      v.rst = ($urandom_range(0, 99) < 3);
      step(v, $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
